bp_fe_bp_update_queue: RTL and testbench
========================================

Name: bp_fe_bp_update_queue

Overview:
- In-order buffer between the front-end branch predictor read port and branch resolution.
- Captures each issued prediction (BHT index, predicted direction) in a FIFO. On each in-order resolution it pops the oldest entry, compares the prediction with the actual outcome, and drives the predictor update port (w_v / idx_w / correct) one cycle later.
- Also provides flush on pipeline redirect, occupancy, and an underflow error flag.

Parameters:
- bht_idx_width_p, 9, BHT index width; must match the predictor's index width.
- els_p, 8, FIFO depth; power of two, ≥2.
- ptr_width_lp (localparam), $clog2(els_p), read/write pointer width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- pred_v_i  in  1  prediction issued this cycle (enqueue request)
- pred_idx_i  in  bht_idx_width_p  BHT index used for the prediction
- pred_taken_i  in  1  predicted direction (predictor predict_o)
- pred_ready_o  out  1  queue can accept an enqueue (= ~full)
- res_v_i  in  1  oldest in-flight branch resolved this cycle
- res_taken_i  in  1  actual branch direction
- flush_i  in  1  discard all in-flight entries
- w_v_o  out  1  predictor update valid
- idx_w_o  out  bht_idx_width_p  predictor update index
- correct_o  out  1  1 = stored prediction matched actual outcome
- count_o  out  ptr_width_lp+1  current occupancy, 0..els_p
- underflow_o  out  1  sticky: resolve arrived while empty

Behaviour:
- Reset (reset_n_i=0 at posedge): pointers, count_o, w_v_o, idx_w_o, correct_o and underflow_o all go to 0. Storage contents are don't-care. Reset mid-operation drops every entry.
- Enqueue: when pred_v_i & pred_ready_o, write {pred_idx_i, pred_taken_i} at wptr; wptr advances mod els_p. If pred_v_i=1 while full, the enqueue is dropped and state is unchanged.
- Resolve: when res_v_i and count≠0, read the entry at rptr; rptr advances mod els_p.
- Next cycle after a resolve: w_v_o=1, idx_w_o = stored idx, correct_o = (stored taken == res_taken_i). Fixed 1-cycle latency.
- w_v_o is high for exactly one cycle per accepted resolve. Otherwise w_v_o=0; idx_w_o and correct_o hold their last value.
- Resolve while empty: no pop and w_v_o=0 next cycle; underflow_o is set and cleared only by reset.
- Simultaneous enqueue and resolve:
  - Not full and not empty: both happen and count is unchanged.
  - Full: the resolve pops, but the enqueue is dropped because pred_ready_o=0 that cycle. No combinational path from res_v_i to pred_ready_o.
  - Empty: no bypass. The resolve underflows and the enqueue proceeds, so count becomes 1.
- Flush:
  - flush_i=1 resets rptr, wptr and count to 0 next cycle.
  - Flush has priority: same-cycle enqueue and resolve are ignored, and w_v_o=0 next cycle.
  - An update already registered in the cycle of the flush still appears on w_v_o.
- Full detection uses count_o == els_p. Pointers wrap naturally because els_p is a power of two.
- pred_ready_o = (count_o != els_p), derived combinationally from registered state only.

Optional Feature:
- Macro: BP_UPDATE_QUEUE_STATS_EN.
- When defined, the block adds two output ports:
  - resolved_cnt_o [31:0]: increments on each w_v_o pulse.
  - mispred_cnt_o [31:0]: increments on each w_v_o pulse with correct_o=0.
- Both counters reset to 0, saturate at 32'hFFFF_FFFF, and are unaffected by flush_i.
- When not defined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset release, then enqueue (idx=5, taken=1), then resolve with res_taken_i=1 two cycles later → next cycle w_v_o=1, idx_w_o=5, correct_o=1; count_o goes 1→0.
- Enqueue 8 entries (idx 0..7, taken alternating 0/1), then resolve all with res_taken_i=1 → w_v_o pulses 8 times, idx_w_o=0..7 in order, correct_o=0,1,0,1,…; pred_ready_o=0 while count_o=8.
- Full queue: assert pred_v_i (idx=9) and res_v_i together → pop occurs, enqueue dropped, count_o=7; the later drain never shows idx 9.
- Fill with 3 entries, then flush_i=1 together with res_v_i=1 → count_o=0 next cycle, w_v_o stays 0; a subsequent resolve sets underflow_o=1 and gives no w_v_o.
- Steady stream of simultaneous enqueue and resolve over 20 cycles at count 4 → count_o stays 4, one w_v_o per cycle, FIFO order preserved across pointer wrap.
- With BP_UPDATE_QUEUE_STATS_EN: 10 resolves including 3 mispredicts → resolved_cnt_o=10, mispred_cnt_o=3; a flush leaves both unchanged; reset clears both.

Source files
------------

// File: rtl/bp_fe_bp_update_queue.sv
// ============================================================================
// bp_fe_bp_update_queue
// ----------------------------------------------------------------------------
// In-order buffer between the front-end branch predictor read port and
// branch resolution. Every issued prediction (BHT index + predicted
// direction) is pushed into a small FIFO. When the oldest in-flight branch
// resolves, its entry is popped and compared against the real outcome. One
// cycle later the predictor update port (w_v_o / idx_w_o / correct_o)
// carries the result.
//
// Parameters:
//   bht_idx_width_p : BHT index width, must match the predictor
//   els_p           : FIFO depth, power of two and >= 2
//
// Ports:
//   clk_i          in   clock
//   reset_n_i      in   synchronous active-low reset
//   pred_v_i       in   enqueue request (prediction issued this cycle)
//   pred_idx_i     in   BHT index used for the prediction
//   pred_taken_i   in   predicted direction
//   pred_ready_o   out  queue can accept an enqueue (not full)
//   res_v_i        in   oldest in-flight branch resolved this cycle
//   res_taken_i    in   actual branch direction
//   flush_i        in   discard all in-flight entries
//   w_v_o          out  predictor update valid (one-cycle pulse)
//   idx_w_o        out  predictor update index
//   correct_o      out  stored prediction matched the actual outcome
//   count_o        out  current occupancy, 0..els_p
//   underflow_o    out  sticky: a resolve arrived while the queue was empty
//
// Optional feature (macro BP_UPDATE_QUEUE_STATS_EN):
//   resolved_cnt_o out  saturating count of update pulses
//   mispred_cnt_o  out  saturating count of update pulses with correct_o=0
// ============================================================================
module bp_fe_bp_update_queue #(
    parameter int bht_idx_width_p = 9,
    parameter int els_p           = 8,
    localparam int ptr_width_lp   = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       pred_v_i,
    input  logic [bht_idx_width_p-1:0] pred_idx_i,
    input  logic                       pred_taken_i,
    output logic                       pred_ready_o,

    input  logic                       res_v_i,
    input  logic                       res_taken_i,
    input  logic                       flush_i,

    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,

    output logic [ptr_width_lp:0]      count_o,
    output logic                       underflow_o
`ifdef BP_UPDATE_QUEUE_STATS_EN
    ,
    output logic [31:0]                resolved_cnt_o,
    output logic [31:0]                mispred_cnt_o
`endif
);

    // ------------------------------------------------------------------------
    // Constants sized to the pointer/count widths so every compare and
    // increment is width-exact.
    // ------------------------------------------------------------------------
    localparam logic [ptr_width_lp:0]   full_count_lp = (ptr_width_lp+1)'(els_p);
    localparam logic [ptr_width_lp:0]   count_one_lp  = (ptr_width_lp+1)'(1);
    localparam logic [ptr_width_lp-1:0] ptr_one_lp    = ptr_width_lp'(1);

    // One stored prediction.
    typedef struct packed {
        logic [bht_idx_width_p-1:0] idx;
        logic                       taken;
    } entry_s;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    entry_s                  mem [els_p];
    logic [ptr_width_lp-1:0] wptr;
    logic [ptr_width_lp-1:0] rptr;
    logic [ptr_width_lp:0]   count;
    logic [ptr_width_lp:0]   count_next;
    logic                    underflow;

    logic                    full;
    logic                    empty;
    logic                    enq;
    logic                    deq;
    logic                    underflow_set;
    entry_s                  head;

    // ------------------------------------------------------------------------
    // Status and handshake decode.
    // Ready depends only on the registered count, so a same-cycle resolve
    // never opens a slot for a same-cycle enqueue when full. Flush wins over
    // both enqueue and resolve, and a resolve that is swallowed by a flush
    // is not treated as an underflow.
    // ------------------------------------------------------------------------
    assign full          = (count == full_count_lp);
    assign empty         = (count == '0);
    assign pred_ready_o  = ~full;

    assign enq           = pred_v_i & ~full  & ~flush_i;
    assign deq           = res_v_i  & ~empty & ~flush_i;
    assign underflow_set = res_v_i  &  empty & ~flush_i;

    assign head          = mem[rptr];

    assign count_o       = count;
    assign underflow_o   = underflow;

    // ------------------------------------------------------------------------
    // Storage array. Contents are don't-care after reset, so it carries no
    // reset; the pointers alone decide what is valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr] <= '{idx: pred_idx_i, taken: pred_taken_i};
        end
    end

    // ------------------------------------------------------------------------
    // Next occupancy. Simultaneous enqueue and dequeue leaves it unchanged.
    // ------------------------------------------------------------------------
    always_comb begin
        count_next = count;
        unique case ({enq, deq})
            2'b10:   count_next = count + count_one_lp;
            2'b01:   count_next = count - count_one_lp;
            default: count_next = count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Pointers and occupancy. Pointers wrap for free since els_p is a power
    // of two. Flush returns everything to the empty state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + ptr_one_lp;
            end
            if (deq) begin
                rptr <= rptr + ptr_one_lp;
            end
            count <= count_next;
        end
    end

    // ------------------------------------------------------------------------
    // Predictor update port. One registered pulse per accepted resolve;
    // index and correctness hold their last value between pulses. An update
    // registered before a flush is still presented because flush only
    // gates new dequeues.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            w_v_o     <= 1'b0;
            idx_w_o   <= '0;
            correct_o <= 1'b0;
        end else begin
            w_v_o <= deq;
            if (deq) begin
                idx_w_o   <= head.idx;
                correct_o <= (head.taken == res_taken_i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky underflow flag, cleared only by reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            underflow <= 1'b0;
        end else if (underflow_set) begin
            underflow <= 1'b1;
        end
    end

`ifdef BP_UPDATE_QUEUE_STATS_EN
    // ------------------------------------------------------------------------
    // Saturating statistics counters driven from the registered update
    // pulse. They ignore flush so they reflect lifetime activity.
    // ------------------------------------------------------------------------
    logic [31:0] resolved_cnt;
    logic [31:0] mispred_cnt;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            resolved_cnt <= '0;
            mispred_cnt  <= '0;
        end else if (w_v_o) begin
            if (resolved_cnt != 32'hFFFF_FFFF) begin
                resolved_cnt <= resolved_cnt + 32'd1;
            end
            if (!correct_o && (mispred_cnt != 32'hFFFF_FFFF)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

    assign resolved_cnt_o = resolved_cnt;
    assign mispred_cnt_o  = mispred_cnt;
`endif

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// ============================================================================
// tb_bp_fe_bp_update_queue
// ----------------------------------------------------------------------------
// Directed self-checking bench for bp_fe_bp_update_queue (default depth 8,
// index width 9). Inputs change #1 after a rising edge and outputs are
// sampled at that same point, so every check sees the state registered by
// the preceding edge.
// ============================================================================
module tb_bp_fe_bp_update_queue;

    logic       clk_i;
    logic       reset_n_i;
    logic       pred_v_i;
    logic [8:0] pred_idx_i;
    logic       pred_taken_i;
    logic       pred_ready_o;
    logic       res_v_i;
    logic       res_taken_i;
    logic       flush_i;
    logic       w_v_o;
    logic [8:0] idx_w_o;
    logic       correct_o;
    logic [3:0] count_o;
    logic       underflow_o;
`ifdef BP_UPDATE_QUEUE_STATS_EN
    logic [31:0] resolved_cnt_o;
    logic [31:0] mispred_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    bp_fe_bp_update_queue #(
        .bht_idx_width_p(9),
        .els_p          (8)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .pred_v_i     (pred_v_i),
        .pred_idx_i   (pred_idx_i),
        .pred_taken_i (pred_taken_i),
        .pred_ready_o (pred_ready_o),
        .res_v_i      (res_v_i),
        .res_taken_i  (res_taken_i),
        .flush_i      (flush_i),
        .w_v_o        (w_v_o),
        .idx_w_o      (idx_w_o),
        .correct_o    (correct_o),
        .count_o      (count_o),
        .underflow_o  (underflow_o)
`ifdef BP_UPDATE_QUEUE_STATS_EN
        ,
        .resolved_cnt_o(resolved_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Predicted direction used for stored entry j in the streaming test.
    function automatic logic takenOf(input int j);
        return j[1];
    endfunction

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then idle them.
    task automatic applyStimulus(input logic pv, input logic [8:0] pidx,
                                 input logic ptaken, input logic rv,
                                 input logic rtaken, input logic fl);
        pred_v_i     = pv;
        pred_idx_i   = pidx;
        pred_taken_i = ptaken;
        res_v_i      = rv;
        res_taken_i  = rtaken;
        flush_i      = fl;
        @(posedge clk_i);
        #1;
        pred_v_i     = 1'b0;
        pred_idx_i   = 9'd0;
        pred_taken_i = 1'b0;
        res_v_i      = 1'b0;
        res_taken_i  = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic applyReset();
        reset_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n_i    = 1'b0;
        pred_v_i     = 1'b0;
        pred_idx_i   = 9'd0;
        pred_taken_i = 1'b0;
        res_v_i      = 1'b0;
        res_taken_i  = 1'b0;
        flush_i      = 1'b0;

        // ---------------- reset state ----------------
        applyReset();
        checkOutput("rst count",     32'(count_o),      32'd0);
        checkOutput("rst w_v",       32'(w_v_o),        32'd0);
        checkOutput("rst idx_w",     32'(idx_w_o),      32'd0);
        checkOutput("rst correct",   32'(correct_o),    32'd0);
        checkOutput("rst underflow", 32'(underflow_o),  32'd0);
        checkOutput("rst ready",     32'(pred_ready_o), 32'd1);
`ifdef BP_UPDATE_QUEUE_STATS_EN
        checkOutput("rst resolved",  resolved_cnt_o,    32'd0);
        checkOutput("rst mispred",   mispred_cnt_o,     32'd0);
`endif

        // ---------------- single enqueue / resolve ----------------
        applyStimulus(1'b1, 9'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t1 count enq", 32'(count_o), 32'd1);
        checkOutput("t1 w_v idle",  32'(w_v_o),   32'd0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t1 w_v",       32'(w_v_o),     32'd1);
        checkOutput("t1 idx_w",     32'(idx_w_o),   32'd5);
        checkOutput("t1 correct",   32'(correct_o), 32'd1);
        checkOutput("t1 count res", 32'(count_o),   32'd0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1 w_v drop",  32'(w_v_o),     32'd0);
        checkOutput("t1 idx hold",  32'(idx_w_o),   32'd5);
        checkOutput("t1 cor hold",  32'(correct_o), 32'd1);

        // ---------------- fill to full ----------------
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 9'(i), takenOf(i << 1), 1'b0, 1'b0, 1'b0);
            checkOutput("t2 fill count", 32'(count_o), 32'(i + 1));
        end
        checkOutput("t2 ready full", 32'(pred_ready_o), 32'd0);
        // Enqueue while full is dropped.
        applyStimulus(1'b1, 9'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t2 full drop count", 32'(count_o), 32'd8);
        checkOutput("t2 full drop w_v",   32'(w_v_o),   32'd0);
        // Full + simultaneous enqueue and resolve: pop only.
        applyStimulus(1'b1, 9'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("t3 count",   32'(count_o),      32'd7);
        checkOutput("t3 w_v",     32'(w_v_o),        32'd1);
        checkOutput("t3 idx_w",   32'(idx_w_o),      32'd0);
        checkOutput("t3 correct", 32'(correct_o),    32'd0);
        checkOutput("t3 ready",   32'(pred_ready_o), 32'd1);
        // Drain the rest: idx 1..7, taken alternates starting at 1.
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput("t2 drain w_v",     32'(w_v_o),     32'd1);
            checkOutput("t2 drain idx",     32'(idx_w_o),   32'(i));
            checkOutput("t2 drain correct", 32'(correct_o), 32'(i % 2));
            checkOutput("t2 drain count",   32'(count_o),   32'(7 - i));
        end
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2 after drain w_v", 32'(w_v_o),       32'd0);
        checkOutput("t2 no underflow",    32'(underflow_o), 32'd0);

        // ---------------- flush ----------------
        applyStimulus(1'b1, 9'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4 count3", 32'(count_o), 32'd3);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t4 pre w_v",   32'(w_v_o),   32'd1);
        checkOutput("t4 pre idx",   32'(idx_w_o), 32'd10);
        checkOutput("t4 pre count", 32'(count_o), 32'd2);
        applyStimulus(1'b1, 9'd13, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("t4 flush count", 32'(count_o),      32'd0);
        checkOutput("t4 flush w_v",   32'(w_v_o),        32'd0);
        checkOutput("t4 flush uf",    32'(underflow_o),  32'd0);
        checkOutput("t4 flush ready", 32'(pred_ready_o), 32'd1);
        checkOutput("t4 flush idx",   32'(idx_w_o),      32'd10);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t4 uf set",   32'(underflow_o), 32'd1);
        checkOutput("t4 uf w_v",   32'(w_v_o),       32'd0);
        checkOutput("t4 uf count", 32'(count_o),     32'd0);
        // Empty + simultaneous enqueue and resolve: no bypass.
        applyStimulus(1'b1, 9'd20, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t4 empty both count", 32'(count_o), 32'd1);
        checkOutput("t4 empty both w_v",   32'(w_v_o),   32'd0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t4 pop20 w_v",     32'(w_v_o),     32'd1);
        checkOutput("t4 pop20 idx",     32'(idx_w_o),   32'd20);
        checkOutput("t4 pop20 correct", 32'(correct_o), 32'd1);
        checkOutput("t4 pop20 count",   32'(count_o),   32'd0);

        // ---------------- steady stream at count 4 ----------------
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 9'(100 + k), takenOf(100 + k), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("t5 prefill", 32'(count_o), 32'd4);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 9'(104 + k), takenOf(104 + k), 1'b1, k[0], 1'b0);
            checkOutput("t5 count",   32'(count_o),   32'd4);
            checkOutput("t5 w_v",     32'(w_v_o),     32'd1);
            checkOutput("t5 idx",     32'(idx_w_o),   32'(100 + k));
            checkOutput("t5 correct", 32'(correct_o),
                        32'(takenOf(100 + k) == k[0]));
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput("t5 drain idx",     32'(idx_w_o),   32'(120 + k));
            checkOutput("t5 drain correct", 32'(correct_o), 32'(takenOf(120 + k)));
            checkOutput("t5 drain count",   32'(count_o),   32'(3 - k));
        end
        checkOutput("t5 uf sticky", 32'(underflow_o), 32'd1);

        // ---------------- reset mid-operation ----------------
        applyStimulus(1'b1, 9'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t6 pre count", 32'(count_o), 32'd2);
        applyReset();
        checkOutput("t6 count",   32'(count_o),     32'd0);
        checkOutput("t6 uf",      32'(underflow_o), 32'd0);
        checkOutput("t6 idx_w",   32'(idx_w_o),     32'd0);
        checkOutput("t6 correct", 32'(correct_o),   32'd0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t6 dropped w_v", 32'(w_v_o),       32'd0);
        checkOutput("t6 dropped uf",  32'(underflow_o), 32'd1);

`ifdef BP_UPDATE_QUEUE_STATS_EN
        // ---------------- statistics counters ----------------
        applyReset();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 9'(k), 1'b1, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, (k >= 3), 1'b0);
        end
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("st resolved", resolved_cnt_o, 32'd10);
        checkOutput("st mispred",  mispred_cnt_o,  32'd3);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("st flush resolved", resolved_cnt_o, 32'd10);
        checkOutput("st flush mispred",  mispred_cnt_o,  32'd3);
        applyReset();
        checkOutput("st rst resolved", resolved_cnt_o, 32'd0);
        checkOutput("st rst mispred",  mispred_cnt_o,  32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
